mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 16, address width in bits.
REQ-002 Parameter: DW, 16, data width in bits.
REQ-003 Parameter: TIMEOUT, 255, maximum wait cycles for mem_ack before abort (1..65535).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 if_req  in  1  fetch-stage read request; held until if_ready.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_rdata  out  DW  fetched instruction; valid while if_ready=1.
REQ-009 if_ready  out  1  one-cycle pulse: fetch done.
REQ-010 d_rd, d_wr  in  1 each  MEM-stage load/store request; held until d_ready.
REQ-011 d_addr, d_wdata  in  AW, DW  data address and store data.
REQ-012 d_rdata  out  DW  load data; valid while d_ready=1.
REQ-013 d_ready  out  1  one-cycle pulse: data access done.
REQ-014 mem_req, mem_we  out  1 each  unified single-port memory request and write enable.
REQ-015 mem_addr, mem_wdata  out  AW, DW  memory address and write data.
REQ-016 mem_rdata  in  DW; mem_ack  in  1  memory read data and one-cycle completion.
REQ-017 stall_f, stall_m  out  1 each  fetch-stage and MEM-stage stall requests to the pipeline.
REQ-018 err_timeout, err_rdwr  out  1 each  sticky error flags.

Function
REQ-019 FSM states SHALL be IDLE, DATA, INSTR; exactly one granted port at a time.
REQ-020 IDLE: if (d_rd|d_wr) and d_ready=0 -> DATA; else if if_req and if_ready=0 -> INSTR; else stay.
REQ-021 Data SHALL have priority, except: after 2 consecutive data grants with if_req pending, the next grant SHALL go to INSTR.
REQ-022 On entry to DATA/INSTR: mem_req=1, mem_addr/mem_wdata/mem_we registered from the granted port, held stable until exit.
REQ-023 mem_we=1 only in DATA with d_wr=1; mem_wdata=d_wdata in DATA, don't-care otherwise.
REQ-024 d_rd and d_wr both 1 SHALL be served as a write and set err_rdwr.
REQ-025 On mem_ack in DATA/INSTR: mem_req deasserts next cycle, FSM -> IDLE, granted port's ready pulses for exactly 1 cycle, read data registered from mem_rdata (writes: d_rdata holds previous value).
REQ-026 Minimum latency: request seen in IDLE at cycle N -> mem_req at N+1 -> mem_ack at N+1 -> ready at N+2.
REQ-027 Wait counter (16 bits) SHALL clear on grant, increment each DATA/INSTR cycle without mem_ack; on reaching TIMEOUT: abort, ready pulses with rdata=0, err_timeout set.
REQ-028 mem_ack in IDLE SHALL be ignored; mem_ack in the same cycle as timeout SHALL win (normal completion, no error).
REQ-029 stall_f = if_req & ~if_ready; stall_m = (d_rd|d_wr) & ~d_ready; combinational.
REQ-030 A port whose ready is 1 in the current cycle SHALL not be granted in that cycle (no double service of a held request).
REQ-031 Error flags SHALL remain set until reset.

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, mem_req=0, mem_we=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, wait counter=0, grant-streak counter=0, err_timeout=0, err_rdwr=0.
REQ-033 Reset mid-transaction SHALL abandon the access; a later mem_ack SHALL be ignored.

Verification
REQ-034 if_req=1, if_addr=16'h0010, ack one cycle after mem_req, mem_rdata=16'h1234 -> if_ready pulse 2 cycles after request with if_rdata=16'h1234; stall_f=1 until then.
REQ-035 if_req and d_rd both raised same cycle, d_addr=16'h0200 -> DATA first (mem_addr=16'h0200), INSTR next; stall_f high throughout both.
REQ-036 Three back-to-back stores with if_req held -> grant order DATA, DATA, INSTR, DATA; mem_we=1 only on data grants.
REQ-037 TIMEOUT=4, d_rd with no mem_ack -> d_ready pulse after 4 wait cycles, d_rdata=0, err_timeout=1 sticky.
REQ-038 reset=0 asserted while in DATA with mem_req=1 -> mem_req=0 same cycle; after release, stray mem_ack produces no ready.
REQ-039 d_rd=d_wr=1 -> memory write performed, err_rdwr=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and MEM stages.
// Data wins by default; after two data grants a waiting fetch gets a turn.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_f,
    output logic          stall_m,
    output logic          err_timeout,
    output logic          err_rdwr
);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} stateT;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    stateT       state;
    stateT       stateNext;
    logic [15:0] waitCnt;
    logic [1:0]  dataStreak;
    logic        dataPend;
    logic        instrPend;
    logic        forceInstr;
    logic        grantData;
    logic        grantInstr;
    logic        busy;
    logic        timeoutHit;
    logic        finish;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next state: choose a port in IDLE, go back on ack or abort.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (grantData)       stateNext = DATA;
                else if (grantInstr) stateNext = INSTR;
            end
            DATA, INSTR: begin
                if (finish) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Decisions: arbitration, completion/abort and stall requests.
    always_comb begin
        dataPend   = (d_rd | d_wr) & ~d_ready;
        instrPend  = if_req & ~if_ready;
        forceInstr = (dataStreak == 2'd2) & instrPend;
        grantData  = (state == IDLE) & dataPend & ~forceInstr;
        grantInstr = (state == IDLE) & instrPend & ~grantData;
        busy       = (state != IDLE);
        timeoutHit = busy & ~mem_ack & ((waitCnt + 16'd1) == TimeoutVal);
        finish     = busy & (mem_ack | timeoutHit);
        mem_req    = busy;
        stall_f    = instrPend;
        stall_m    = dataPend;
    end

    // Datapath: latch the granted request, count waits, retire accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_ready    <= 1'b0;
            d_ready     <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            waitCnt     <= '0;
            dataStreak  <= '0;
            err_timeout <= 1'b0;
            err_rdwr    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (grantData) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_we    <= d_wr;
                waitCnt   <= '0;
                if (dataStreak != 2'd2) dataStreak <= dataStreak + 2'd1;
                if (d_rd & d_wr) err_rdwr <= 1'b1;
            end else if (grantInstr) begin
                mem_addr   <= if_addr;
                mem_we     <= 1'b0;
                waitCnt    <= '0;
                dataStreak <= '0;
            end else if (busy & ~finish) begin
                waitCnt <= waitCnt + 16'd1;
            end
            if (finish) begin
                mem_we <= 1'b0;
                if (timeoutHit) err_timeout <= 1'b1;
                if (state == DATA) begin
                    d_ready <= 1'b1;
                    if (timeoutHit)   d_rdata <= '0;
                    else if (!mem_we) d_rdata <= mem_rdata;
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= timeoutHit ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level arbiter model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_f;
    logic        stall_m;
    logic        err_timeout;
    logic        err_rdwr;

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall_f(stall_f), .stall_m(stall_m),
        .err_timeout(err_timeout), .err_rdwr(err_rdwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: 0 = nobody owns the memory, 1 = data port, 2 = fetch port
    int          mOwner;
    int          mWaited;
    int          mDataRun;
    logic        mIfReady, mDReady, mWe, mErrTo, mErrRw;
    logic [15:0] mIfRdata, mDRdata, mAddr, mWdata;

    bit          dDone, ifDone, prevReq;
    int          ackAfter, memCycles, directAck;
    bit          strayFix, useFix;
    logic [15:0] fixData;
    logic [15:0] addrLog[$];
    logic        weLog[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkInt(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner = 0; mWaited = 0; mDataRun = 0;
        mIfReady = 0; mDReady = 0; mWe = 0; mErrTo = 0; mErrRw = 0;
        mIfRdata = 0; mDRdata = 0; mAddr = 0; mWdata = 0;
    endtask

    // One clock edge of the arbiter, stated as transaction rules.
    task automatic modelStep();
        logic nIf, nD;
        bit   dw, iw, aborted;
        nIf = 0;
        nD  = 0;
        if (mOwner == 0) begin
            dw = (d_rd || d_wr) && !mDReady;
            iw = if_req && !mIfReady;
            if (dw && !(mDataRun >= 2 && iw)) begin
                mOwner = 1; mAddr = d_addr; mWdata = d_wdata;
                mWe = d_wr; mWaited = 0; mDataRun++;
                if (d_rd && d_wr) mErrRw = 1;
            end else if (iw) begin
                mOwner = 2; mAddr = if_addr; mWe = 0;
                mWaited = 0; mDataRun = 0;
            end
        end else begin
            aborted = 0;
            if (!mem_ack) begin
                mWaited++;
                aborted = (mWaited >= TO);
            end
            if (mem_ack || aborted) begin
                if (mOwner == 1) begin
                    nD = 1;
                    if (aborted)   mDRdata = 16'h0;
                    else if (!mWe) mDRdata = mem_rdata;
                end else begin
                    nIf = 1;
                    mIfRdata = aborted ? 16'h0 : mem_rdata;
                end
                if (aborted) mErrTo = 1;
                mOwner = 0;
                mWe = 0;
            end
        end
        mIfReady = nIf;
        mDReady  = nD;
    endtask

    task automatic checkAll();
        chk1("mem_req", mem_req, mOwner != 0);
        chk1("if_ready", if_ready, mIfReady);
        chk1("d_ready", d_ready, mDReady);
        chk16("if_rdata", if_rdata, mIfRdata);
        chk16("d_rdata", d_rdata, mDRdata);
        chk1("mem_we", mem_we, mWe);
        chk1("err_timeout", err_timeout, mErrTo);
        chk1("err_rdwr", err_rdwr, mErrRw);
        chk1("stall_f", stall_f, if_req && !mIfReady);
        chk1("stall_m", stall_m, (d_rd || d_wr) && !mDReady);
        if (mOwner != 0) chk16("mem_addr", mem_addr, mAddr);
        if (mOwner == 1) chk16("mem_wdata", mem_wdata, mWdata);
        if (mem_req && !prevReq) begin
            addrLog.push_back(mem_addr);
            weLog.push_back(mem_we);
        end
        prevReq = mem_req;
    endtask

    task automatic memDrive(input bit rnd);
        if (mOwner == 0) begin
            memCycles = 0;
            ackAfter  = rnd ? int'($urandom_range(0, 5)) : directAck;
            mem_ack   = rnd ? ($urandom_range(0, 7) == 0) : strayFix;
        end else begin
            mem_ack = (ackAfter >= 0) && (memCycles == ackAfter);
            memCycles++;
        end
        mem_rdata = useFix ? fixData : 16'($urandom);
    endtask

    // Called at posedge+1: drive inputs, compare, advance one edge.
    task automatic step(input bit rnd);
        int r;
        if (dDone) begin d_rd = 0; d_wr = 0; dDone = 0; end
        if (ifDone) begin if_req = 0; ifDone = 0; end
        if (rnd) begin
            if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 9));
                d_rd    = (r < 5) || (r == 9);
                d_wr    = (r >= 5);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = 16'($urandom);
            end
        end
        if ((d_rd || d_wr) && mDReady) dDone = 1;
        if (if_req && mIfReady) ifDone = 1;
        memDrive(rnd);
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic runUntilIdle(input string nm);
        int n;
        n = 0;
        do begin
            step(0);
            n++;
        end while ((d_rd || d_wr || if_req) && n < 40);
        checks++;
        if (d_rd || d_wr || if_req) begin
            errors++;
            $display("FAIL %s: request still open after %0d cycles", nm, n);
        end
    endtask

    // Async reset away from clock edges; outputs must clear at once.
    task automatic resetPulse(input string nm);
        #2;
        reset = 0;
        d_rd = 0; d_wr = 0; if_req = 0; mem_ack = 0;
        dDone = 0; ifDone = 0; strayFix = 0;
        modelReset();
        #1;
        chk1({nm, "_mem_req"}, mem_req, 1'b0);
        chk1({nm, "_mem_we"}, mem_we, 1'b0);
        chk1({nm, "_d_ready"}, d_ready, 1'b0);
        chk1({nm, "_if_ready"}, if_ready, 1'b0);
        chk16({nm, "_mem_addr"}, mem_addr, 16'h0);
        chk16({nm, "_d_rdata"}, d_rdata, 16'h0);
        chk1({nm, "_err_to"}, err_timeout, 1'b0);
        chk1({nm, "_err_rw"}, err_rdwr, 1'b0);
        prevReq = 0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, cnt, n;
        reset = 1; if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
        dDone = 0; ifDone = 0; prevReq = 0; ackAfter = 0; memCycles = 0;
        directAck = 0; strayFix = 0; useFix = 0; fixData = 0;
        modelReset();
        #1;
        resetPulse("rst");

        // fetch, ack in the first mem_req cycle
        directAck = 0; useFix = 1; fixData = 16'h1234;
        if_addr = 16'h0010; if_req = 1;
        step(0);
        chk1("f_memreq", mem_req, 1'b1);
        chk16("f_addr", mem_addr, 16'h0010);
        chk1("f_stall_on", stall_f, 1'b1);
        step(0);
        chk1("f_ready", if_ready, 1'b1);
        chk16("f_rdata", if_rdata, 16'h1234);
        chk1("f_stall_off", stall_f, 1'b0);
        step(0);
        chk1("f_pulse", if_ready, 1'b0);
        runUntilIdle("f_idle");
        useFix = 0;

        // simultaneous load and fetch: data first
        base = addrLog.size();
        d_addr = 16'h0200; d_rd = 1; if_addr = 16'h0020; if_req = 1;
        step(0);
        chk16("df_addr", mem_addr, 16'h0200);
        chk1("df_we", mem_we, 1'b0);
        chk1("df_stallf", stall_f, 1'b1);
        step(0);
        chk1("df_stallf2", stall_f, 1'b1);
        runUntilIdle("df_idle");
        chk16("df_g0", addrLog[base], 16'h0200);
        chk16("df_g1", addrLog[base + 1], 16'h0020);

        // two lone stores, then store + fetch: fetch takes its turn
        base = addrLog.size();
        d_wr = 1; d_addr = 16'h0301; d_wdata = 16'haaaa;
        runUntilIdle("st1");
        d_wr = 1; d_addr = 16'h0302; d_wdata = 16'hbbbb;
        runUntilIdle("st2");
        d_wr = 1; d_addr = 16'h0303; d_wdata = 16'hcccc;
        if_req = 1; if_addr = 16'h0040;
        runUntilIdle("st3");
        chk16("st_g0", addrLog[base], 16'h0301);
        chk16("st_g1", addrLog[base + 1], 16'h0302);
        chk16("st_g2", addrLog[base + 2], 16'h0040);
        chk16("st_g3", addrLog[base + 3], 16'h0303);
        chk1("st_we0", weLog[base], 1'b1);
        chk1("st_we2", weLog[base + 2], 1'b0);
        chk1("st_we3", weLog[base + 3], 1'b1);

        // read and write together: served as a write
        d_rd = 1; d_wr = 1; d_addr = 16'h0500; d_wdata = 16'h5a5a;
        step(0);
        chk1("rw_we", mem_we, 1'b1);
        chk16("rw_wdata", mem_wdata, 16'h5a5a);
        runUntilIdle("rw_idle");
        chk1("rw_err", err_rdwr, 1'b1);

        // no ack: abort after TO wait cycles
        directAck = -1;
        d_rd = 1; d_addr = 16'h0600;
        cnt = 0; n = 0;
        do begin
            step(0);
            if (mem_req) cnt++;
            n++;
        end while (!d_ready && n < 20);
        chkInt("to_cycles", cnt, TO);
        chk1("to_ready", d_ready, 1'b1);
        chk16("to_rdata", d_rdata, 16'h0);
        chk1("to_err", err_timeout, 1'b1);
        runUntilIdle("to_idle");
        step(0);
        chk1("to_sticky", err_timeout, 1'b1);

        // reset during DATA, then a stray ack
        d_rd = 1; d_addr = 16'h0700;
        step(0);
        chk1("mr_memreq", mem_req, 1'b1);
        resetPulse("mr");
        strayFix = 1;
        step(0);
        strayFix = 0;
        step(0);
        chk1("mr_dready", d_ready, 1'b0);
        chk1("mr_ifready", if_ready, 1'b0);
        chk1("mr_memreq2", mem_req, 1'b0);

        // random traffic with random ack delay and stray acks
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (i == 1500) resetPulse("rr");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
